// File: rtl/serial_addsub_rx.sv
// serial_addsub_rx: bit-serial adder/subtractor that rebuilds a WIDTH-bit word on the io_in/io_out tile; define OVERFLOW_FLAG_EN to put signed overflow on io_out[3] instead of busy
module serial_addsub_rx #(
    parameter int WIDTH = 4
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t r_state, w_next;
    logic w_clk, w_rst, w_start, w_a, w_b, w_sub, w_valid, w_unused;
    logic r_carry, r_sub, r_sum, r_cout;
    logic [CW-1:0] r_cnt;
    logic [WIDTH-1:0] r_sr, r_result;
    logic w_bp, w_s, w_cnext, w_take, w_last, w_flag;
    logic [3:0] w_res;
`ifdef OVERFLOW_FLAG_EN
    logic r_ovf;
`endif
    assign {w_unused, w_valid, w_sub, w_b, w_a, w_start, w_rst, w_clk} = io_in;
    assign w_take  = (r_state == RUN) && !w_start && w_valid;
    assign w_last  = r_cnt == CW'(WIDTH - 1);
    assign w_bp    = w_b ^ r_sub;
    assign w_s     = w_a ^ w_bp ^ r_carry;
    assign w_cnext = (w_a & w_bp) | (w_a & r_carry) | (w_bp & r_carry);
`ifdef OVERFLOW_FLAG_EN
    assign w_flag = r_ovf;
`else
    assign w_flag = r_state != IDLE;
`endif
    assign io_out = {w_res, w_flag, r_state == DONE, r_cout, r_sum};
    // zero-extend the result word onto io_out[7:4]
    always_comb begin
        w_res = '0;
        w_res[WIDTH-1:0] = r_result;
    end
    // start re-arms from any state; DONE lasts exactly one cycle
    always_comb begin
        w_next = r_state;
        if (w_start)
            w_next = RUN;
        else if (r_state == DONE)
            w_next = IDLE;
        else if (w_take && w_last)
            w_next = DONE;
    end
    // state register
    always_ff @(posedge w_clk) begin
        if (w_rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    // full-adder datapath; result and flags are captured on the last-bit edge so they are visible alongside done
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_carry  <= 1'b0;
            r_sub    <= 1'b0;
            r_sum    <= 1'b0;
            r_cout   <= 1'b0;
            r_cnt    <= '0;
            r_sr     <= '0;
            r_result <= '0;
`ifdef OVERFLOW_FLAG_EN
            r_ovf    <= 1'b0;
`endif
        end else if (w_start) begin
            r_sub   <= w_sub;
            r_carry <= w_sub;
            r_cnt   <= '0;
            r_sr    <= '0;
        end else if (w_take) begin
            r_sum   <= w_s;
            r_carry <= w_cnext;
            r_sr    <= {w_s, r_sr[WIDTH-1:1]};
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_result <= {w_s, r_sr[WIDTH-1:1]};
                r_cout   <= w_cnext;
`ifdef OVERFLOW_FLAG_EN
                r_ovf    <= r_carry ^ w_cnext;
`endif
            end
        end
    end
endmodule

// File: doc/serial_addsub_rx.md
Name: serial_addsub_rx

Overview:
- Bit-serial adder/subtractor for a user slot on the 8-bit io_in/io_out tile interface.
- Takes two operand streams, A and B, LSB-first, one bit per qualified clock. Each bit goes through a single full-adder cell with a registered carry, so sum and carry are produced serially.
- It is the sequential consumer side of our combinational sum/carry logic.
- It rebuilds a WIDTH-bit result word and reports a carry/borrow flag and a done pulse.

Parameters:
- WIDTH, 4, operand/result width in bits. Legal range 2..4, limited by io_out[7:4].

Ports:
- io_in[0]  input  1  clk. Single clock; all state changes on its rising edge.
- io_in[1]  input  1  rst. Synchronous, active-high reset.
- io_in[2]  input  1  start. Arms a new frame from any state.
- io_in[3]  input  1  a_bit. Serial operand A, LSB first.
- io_in[4]  input  1  b_bit. Serial operand B, LSB first.
- io_in[5]  input  1  sub. 0 = A+B, 1 = A-B. Sampled only with start.
- io_in[6]  input  1  valid. Qualifies a_bit/b_bit in RUN.
- io_in[7]  input  1  unused. Ignored.
- io_out[0] output 1  sum_bit. Registered serial sum of the last consumed bit.
- io_out[1] output 1  cout. Final carry; for subtraction, 1 = no borrow. Latched at DONE.
- io_out[2] output 1  done. One-cycle pulse when the result word is complete.
- io_out[3] output 1  busy, or ovf when OVERFLOW_FLAG_EN is defined.
- io_out[7:4] output 4 result. Zero-extended above WIDTH; latched at DONE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; carry, bit counter and shift register clear.
  - All io_out bits are 0 from the following cycle.
  - Reset has priority over start and valid, including mid-frame; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 moves to RUN.
  - The sub flag is latched.
  - Carry is initialised to sub (1 for subtraction, two's complement).
  - Bit counter and shift register clear.
  - Bits on the start cycle are not consumed, even if valid=1.
- RUN:
  - Each edge with valid=1 consumes one bit pair. Let b' = b_bit XOR sub_latched:
    - s = a_bit XOR b' XOR carry
    - carry <= majority(a_bit, b', carry)
    - sum_bit <= s
    - shift register <= {s, sr[WIDTH-1:1]}
    - counter increments
  - valid=0: all state holds and sum_bit holds.
  - When the WIDTH-th bit is consumed, go to DONE.
  - start=1 in RUN aborts the frame and re-arms exactly as from IDLE. Any concurrent valid is ignored and there is no done pulse.
- DONE (exactly one cycle):
  - done=1.
  - result <= shift register.
  - cout <= carry.
  - Next state is IDLE, or RUN if start=1 on this cycle.
- Latency: done is asserted in the cycle after the edge that consumes the last bit. result and cout are valid in the same cycle as done and hold until the next DONE or reset.
- busy = 1 in RUN and DONE, 0 in IDLE. Registered.
- Counter width is clog2(WIDTH)+1; it never wraps inside a frame.
- Extra valid bits in IDLE are ignored.

Optional Feature:
- Macro: OVERFLOW_FLAG_EN.
- Defined: io_out[3] = ovf, the signed overflow. This is the carry into the MSB XOR the carry out of the MSB, latched at DONE and held like result. busy is not exported.
- Undefined: io_out[3] = busy, and no overflow logic is built.

Test Plan:
- Add 3+5, WIDTH=4:
  - Stimulus: rst, then start with sub=0, then 4 valid cycles with a=1,1,0,0 and b=1,0,1,0.
  - Response: done one cycle later; result=4'b1000, cout=0; ovf=1 if the macro is defined.
- Add 9+8:
  - Stimulus: a=1,0,0,1 and b=0,0,0,1.
  - Response: result=4'b0001, cout=1, ovf=1.
- Subtract 5-3 and 3-5 (sub=1):
  - 5-3: result=4'b0010, cout=1.
  - 3-5: result=4'b1110, cout=0, ovf=0.
- Valid gaps:
  - Stimulus: 3+5 with valid=0 for 2 cycles between bit 1 and bit 2.
  - Response: same result as the first scenario; sum_bit holds during the gaps; done appears only after the 4th valid bit.
- Abort and reset:
  - start after 2 bits, then a full 1+1 frame: result=4'b0010, exactly one done pulse.
  - rst after 3 bits: all outputs 0 the next cycle, no done pulse; a later 2+2 frame gives result=4'b0100.
